// File: rtl/branch_predictor_ctrl_if.sv
// Fetch lookup, D-stage resolution and redirect signals of the branch predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_ctrl_if;
   logic        f_valid;
   logic [12:0] f_pc;
   logic        pred_taken;
   logic [12:0] pred_pc;
   logic        u_valid;
   logic [12:0] u_pc;
   logic [1:0]  u_jump_code;
   logic        u_taken;
   logic [12:0] u_true_pc;
   logic        u_fail;
   logic        redirect_valid;
   logic [12:0] redirect_pc;
   logic        redirect_ready;
   logic        flush;
   logic [15:0] miss_cnt;

   modport master (
      output f_valid, f_pc, u_valid, u_pc, u_jump_code, u_taken, u_true_pc, u_fail, redirect_ready,
      input  pred_taken, pred_pc, redirect_valid, redirect_pc, flush, miss_cnt
   );

   modport slave (
      input  f_valid, f_pc, u_valid, u_pc, u_jump_code, u_taken, u_true_pc, u_fail, redirect_ready,
      output pred_taken, pred_pc, redirect_valid, redirect_pc, flush, miss_cnt
   );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// Direct-mapped branch target buffer with 2-bit counters, plus a redirect FSM
// that holds a misprediction redirect until fetch accepts it.
//
// state | meaning
// IDLE  | no redirect outstanding; table updates and new fails accepted
// PEND  | redirect_valid held, waiting for redirect_ready; D-stage input is wrong path
module branch_predictor_ctrl #(
   parameter int IDX_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_predictor_ctrl_if.slave bus
);
   localparam int N     = 1 << IDX_W;
   localparam int TAG_W = 13 - IDX_W;

   typedef enum logic {IDLE, PEND} state_t;

   state_t state, state_nxt;

   logic [N-1:0]     tbl_valid;
   logic [TAG_W-1:0] tbl_tag    [N];
   logic [12:0]      tbl_target [N];
   logic [1:0]       tbl_ctr    [N];

   logic [IDX_W-1:0] f_idx, u_idx;
   logic             f_hit, u_hit, upd_en, fail_acc;
   logic             pred_taken_c;
   logic [12:0]      redirect_pc_q;
   logic [15:0]      miss_q;

   assign f_idx    = bus.f_pc[IDX_W-1:0];
   assign u_idx    = bus.u_pc[IDX_W-1:0];
   assign f_hit    = tbl_valid[f_idx] && (tbl_tag[f_idx] == bus.f_pc[12:IDX_W]);
   assign u_hit    = tbl_valid[u_idx] && (tbl_tag[u_idx] == bus.u_pc[12:IDX_W]);
   assign upd_en   = bus.u_valid && (state == IDLE);
   assign fail_acc = upd_en && bus.u_fail;

   // Lookup reads the registered table, so a same-cycle update is not visible yet.
   always_comb begin
      pred_taken_c = bus.f_valid && f_hit && tbl_ctr[f_idx][1];
      bus.pred_pc  = bus.f_pc + 13'd2;
      if (pred_taken_c) bus.pred_pc = tbl_target[f_idx];
   end
   assign bus.pred_taken = pred_taken_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_valid <= '0;
         for (int i = 0; i < N; i++) begin
            tbl_tag[i]    <= '0;
            tbl_target[i] <= '0;
            tbl_ctr[i]    <= 2'b01;
         end
      end else if (upd_en) begin
         if (u_hit) begin
            if (bus.u_jump_code[1])
               tbl_ctr[u_idx] <= 2'b11;
            else if (bus.u_jump_code == 2'b01) begin
               if (bus.u_taken && tbl_ctr[u_idx] != 2'b11)
                  tbl_ctr[u_idx] <= tbl_ctr[u_idx] + 2'd1;
               else if (!bus.u_taken && tbl_ctr[u_idx] != 2'b00)
                  tbl_ctr[u_idx] <= tbl_ctr[u_idx] - 2'd1;
            end
            if (bus.u_taken) tbl_target[u_idx] <= bus.u_true_pc;
         end else if (bus.u_taken) begin
            tbl_valid[u_idx]  <= 1'b1;
            tbl_tag[u_idx]    <= bus.u_pc[12:IDX_W];
            tbl_target[u_idx] <= bus.u_true_pc;
            tbl_ctr[u_idx]    <= bus.u_jump_code[1] ? 2'b11 : 2'b10;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         redirect_pc_q <= '0;
         miss_q        <= '0;
      end else begin
         state <= state_nxt;
         if (fail_acc) begin
            redirect_pc_q <= bus.u_true_pc;
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fail_acc) state_nxt = PEND;
         PEND:    if (bus.redirect_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.redirect_valid = (state == PEND);
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.flush          = (state == PEND) && bus.redirect_ready;
   assign bus.miss_cnt       = miss_q;
endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Bench for branch_predictor_ctrl: directed scenarios plus randomized traffic
// against a table/queue-level reference model.
module tb_branch_predictor_ctrl;
   localparam int N = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   branch_predictor_ctrl_if bif();

   branch_predictor_ctrl #(.IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bif));

   always #5 clk = ~clk;

   // Reference model: each slot remembers the full PC that owns it.
   logic        m_valid [N];
   logic [12:0] m_pc    [N];
   logic [12:0] m_tgt   [N];
   int          m_ctr   [N];
   bit          m_pend;
   logic [12:0] m_rpc;
   int          m_miss;

   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
      end
      m_pend = 1'b0; m_rpc = '0; m_miss = 0;
   endfunction

   function automatic void m_pred(output logic t, output logic [12:0] npc);
      int i;
      i   = int'(bif.f_pc) % N;
      t   = bif.f_valid && m_valid[i] && (m_pc[i] == bif.f_pc) && (m_ctr[i] >= 2);
      npc = t ? m_tgt[i] : bif.f_pc + 13'd2;
   endfunction

   function automatic void m_commit();
      int  i;
      bit  hit;
      bit  is_jump;
      if (!m_pend) begin
         if (bif.u_valid) begin
            i       = int'(bif.u_pc) % N;
            hit     = m_valid[i] && (m_pc[i] == bif.u_pc);
            is_jump = (bif.u_jump_code >= 2);
            if (hit) begin
               if (is_jump)          m_ctr[i] = 3;
               else if (bif.u_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               else                  m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
               if (bif.u_taken) m_tgt[i] = bif.u_true_pc;
            end else if (bif.u_taken) begin
               m_valid[i] = 1'b1; m_pc[i] = bif.u_pc; m_tgt[i] = bif.u_true_pc;
               m_ctr[i] = is_jump ? 3 : 2;
            end
            if (bif.u_fail) begin
               m_pend = 1'b1; m_rpc = bif.u_true_pc;
               if (m_miss < 65535) m_miss++;
            end
         end
      end else if (bif.redirect_ready) begin
         m_pend = 1'b0;
      end
   endfunction

   function automatic logic [12:0] pick_pc();
      if ($urandom % 8 == 0) return 13'($urandom);
      return 13'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
   endfunction

   task automatic clr_in();
      bif.f_valid = 0; bif.f_pc = '0; bif.u_valid = 0; bif.u_pc = '0; bif.u_jump_code = 2'b00;
      bif.u_taken = 0; bif.u_true_pc = '0; bif.u_fail = 0; bif.redirect_ready = 0;
   endtask

   task automatic tick();
      m_commit();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_upd(input logic [12:0] pc, input logic [1:0] jc, input logic tk,
                          input logic [12:0] tpc, input logic fl);
      bif.u_valid = 1; bif.u_pc = pc; bif.u_jump_code = jc; bif.u_taken = tk;
      bif.u_true_pc = tpc; bif.u_fail = fl;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1; m_reset(); clr_in();
      bif.f_valid = 1; bif.f_pc = 13'h010; bif.redirect_ready = 1;
      #1;
      total++; if (bif.pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%0b exp=0", bif.pred_taken); end
      total++; if (bif.pred_pc !== 13'h012) begin bad++; $display("FAIL reset_pred_pc got=%h exp=012", bif.pred_pc); end
      total++; if (bif.redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redirect_valid got=%0b exp=0", bif.redirect_valid); end
      total++; if (bif.redirect_pc !== 13'h000) begin bad++; $display("FAIL reset_redirect_pc got=%h exp=000", bif.redirect_pc); end
      total++; if (bif.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", bif.flush); end
      total++; if (bif.miss_cnt !== 16'd0) begin bad++; $display("FAIL reset_miss_cnt got=%0d exp=0", bif.miss_cnt); end
      @(negedge clk);
      rst = 0;
      #1;
      total++; if (bif.pred_taken !== 1'b0 || bif.pred_pc !== 13'h012) begin
         bad++; $display("FAIL post_reset_lookup got=%0b/%h exp=0/012", bif.pred_taken, bif.pred_pc); end
      tick();
   endtask

   task automatic test_alloc_hit();
      clr_in();
      set_upd(13'h013, 2'b01, 1'b1, 13'h040, 1'b0);
      bif.f_valid = 1; bif.f_pc = 13'h013;
      #1;
      total++; if (bif.pred_taken !== 1'b0) begin bad++; $display("FAIL same_cycle_pre_update got=%0b exp=0", bif.pred_taken); end
      tick();
      clr_in(); bif.f_valid = 1; bif.f_pc = 13'h013;
      #1;
      total++; if (bif.pred_taken !== 1'b1 || bif.pred_pc !== 13'h040) begin
         bad++; $display("FAIL alloc_hit got=%0b/%h exp=1/040", bif.pred_taken, bif.pred_pc); end
      tick();
   endtask

   task automatic test_saturation();
      logic exp_t [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [12:0] exp_pc;
      for (int k = 0; k < 5; k++) begin
         clr_in(); set_upd(13'h013, 2'b01, (k < 3), 13'h040, 1'b0);
         tick();
         clr_in(); bif.f_valid = 1; bif.f_pc = 13'h013;
         exp_pc = exp_t[k] ? 13'h040 : 13'h015;
         #1;
         total++; if (bif.pred_taken !== exp_t[k] || bif.pred_pc !== exp_pc) begin
            bad++; $display("FAIL saturation_step%0d got=%0b/%h exp=%0b/%h", k, bif.pred_taken, bif.pred_pc, exp_t[k], exp_pc); end
         tick();
      end
   endtask

   task automatic test_backpressure_wrong_path();
      clr_in(); set_upd(13'h055, 2'b01, 1'b0, 13'h100, 1'b1);
      #1;
      total++; if (bif.redirect_valid !== 1'b0) begin bad++; $display("FAIL redirect_not_early got=%0b exp=0", bif.redirect_valid); end
      tick();
      for (int k = 0; k < 3; k++) begin
         clr_in();
         if (k == 1) set_upd(13'h066, 2'b01, 1'b1, 13'h200, 1'b1);
         #1;
         total++; if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 13'h100 || bif.flush !== 1'b0) begin
            bad++; $display("FAIL backpressure_hold%0d got=%0b/%h/%0b exp=1/100/0", k, bif.redirect_valid, bif.redirect_pc, bif.flush); end
         total++; if (bif.miss_cnt !== 16'd1) begin bad++; $display("FAIL backpressure_miss%0d got=%0d exp=1", k, bif.miss_cnt); end
         tick();
      end
      clr_in(); bif.redirect_ready = 1;
      #1;
      total++; if (bif.flush !== 1'b1 || bif.redirect_valid !== 1'b1) begin
         bad++; $display("FAIL ready_flush got=%0b/%0b exp=1/1", bif.flush, bif.redirect_valid); end
      tick();
      clr_in(); bif.redirect_ready = 1; bif.f_valid = 1; bif.f_pc = 13'h066;
      #1;
      total++; if (bif.redirect_valid !== 1'b0 || bif.flush !== 1'b0) begin
         bad++; $display("FAIL after_accept got=%0b/%0b exp=0/0", bif.redirect_valid, bif.flush); end
      total++; if (bif.redirect_pc !== 13'h100 || bif.miss_cnt !== 16'd1) begin
         bad++; $display("FAIL wrong_path_ignored got=%h/%0d exp=100/1", bif.redirect_pc, bif.miss_cnt); end
      total++; if (bif.pred_taken !== 1'b0 || bif.pred_pc !== 13'h068) begin
         bad++; $display("FAIL wrong_path_table got=%0b/%h exp=0/068", bif.pred_taken, bif.pred_pc); end
      tick();
   endtask

   task automatic test_wrap_reset();
      clr_in(); bif.f_valid = 1; bif.f_pc = 13'h1FFF;
      #1;
      total++; if (bif.pred_taken !== 1'b0 || bif.pred_pc !== 13'h0001) begin
         bad++; $display("FAIL wrap got=%0b/%h exp=0/0001", bif.pred_taken, bif.pred_pc); end
      tick();
      clr_in(); set_upd(13'h030, 2'b10, 1'b1, 13'h0AA, 1'b1);
      tick();
      clr_in(); bif.f_valid = 1; bif.f_pc = 13'h030;
      #1;
      total++; if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 13'h0AA || bif.pred_pc !== 13'h0AA) begin
         bad++; $display("FAIL pend_before_rst got=%0b/%h/%h exp=1/0aa/0aa", bif.redirect_valid, bif.redirect_pc, bif.pred_pc); end
      #2;
      rst = 1; bif.redirect_ready = 1; m_reset();
      #1;
      total++; if (bif.redirect_valid !== 1'b0 || bif.flush !== 1'b0) begin
         bad++; $display("FAIL async_rst_drop got=%0b/%0b exp=0/0", bif.redirect_valid, bif.flush); end
      total++; if (bif.miss_cnt !== 16'd0 || bif.pred_taken !== 1'b0 || bif.pred_pc !== 13'h032) begin
         bad++; $display("FAIL async_rst_clear got=%0d/%0b/%h exp=0/0/032", bif.miss_cnt, bif.pred_taken, bif.pred_pc); end
      @(negedge clk);
      rst = 0; clr_in();
      tick();
   endtask

   task automatic test_random();
      logic        et;
      logic [12:0] epc;
      for (int c = 0; c < 800; c++) begin
         bif.f_valid = ($urandom % 4 != 0);
         bif.f_pc = pick_pc();
         bif.u_valid = $urandom % 2;
         bif.u_pc = pick_pc();
         bif.u_jump_code = 2'($urandom_range(1, 3));
         bif.u_taken = bif.u_jump_code[1] ? 1'b1 : 1'($urandom % 2);
         bif.u_true_pc = 13'($urandom);
         bif.u_fail = ($urandom % 5 == 0);
         bif.redirect_ready = ($urandom % 3 == 0);
         m_pred(et, epc);
         #1;
         total++; if (bif.pred_taken !== et || bif.pred_pc !== epc) begin
            bad++; $display("FAIL rnd_pred cyc=%0d got=%0b/%h exp=%0b/%h", c, bif.pred_taken, bif.pred_pc, et, epc); end
         total++; if (bif.redirect_valid !== m_pend || bif.flush !== (m_pend && bif.redirect_ready)) begin
            bad++; $display("FAIL rnd_redirect cyc=%0d got=%0b/%0b exp=%0b/%0b", c, bif.redirect_valid, bif.flush, m_pend, m_pend && bif.redirect_ready); end
         total++; if (bif.redirect_pc !== m_rpc || bif.miss_cnt !== 16'(m_miss)) begin
            bad++; $display("FAIL rnd_state cyc=%0d got=%h/%0d exp=%h/%0d", c, bif.redirect_pc, bif.miss_cnt, m_rpc, m_miss); end
         tick();
      end
   endtask

   initial begin
      clr_in();
      m_reset();
      test_reset();
      test_alloc_hit();
      test_saturation();
      test_backpressure_wrong_path();
      test_wrap_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_predictor_ctrl.md
BRANCH_PREDICTOR_CTRL -- requirements
Module: branch_predictor_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, giving the table index width (2**IDX_W entries).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port f_valid, input, 1 bit: fetch lookup request.
REQ-005 SHALL have port f_pc, input, 13 bits: word address of the fetch pair.
REQ-006 SHALL have port pred_taken, output, 1 bit: predict that the fetch pair redirects.
REQ-007 SHALL have port pred_pc, output, 13 bits: predicted next fetch PC.
REQ-008 SHALL have port u_valid, input, 1 bit: D-stage resolution valid (jump_code != 00 and PC calculable).
REQ-009 SHALL have port u_pc, input, 13 bits: PC of the resolved control instruction.
REQ-010 SHALL have port u_jump_code, input, 2 bits: 01 = branch, 10 = jal, 11 = jalr.
REQ-011 SHALL have port u_taken, input, 1 bit: resolved outcome (branch flag or jump).
REQ-012 SHALL have port u_true_pc, input, 13 bits: resolved next PC.
REQ-013 SHALL have port u_fail, input, 1 bit: the D stage detected a misprediction.
REQ-014 SHALL have port redirect_valid, output, 1 bit: redirect request to fetch.
REQ-015 SHALL have port redirect_pc, output, 13 bits: redirect target.
REQ-016 SHALL have port redirect_ready, input, 1 bit: fetch accepts the redirect.
REQ-017 SHALL have port flush, output, 1 bit: one-cycle pulse to squash younger instructions.
REQ-018 SHALL have port miss_cnt, output, 16 bits: misprediction count.

Function
REQ-019 SHALL give each entry the fields: valid, tag = pc[12:IDX_W], target[12:0], ctr[1:0].
REQ-020 SHALL compute the lookup combinationally from f_pc[IDX_W-1:0]; hit = valid and tag match.
REQ-021 SHALL drive pred_taken = f_valid & hit & ctr[1].
REQ-022 SHALL drive pred_pc = target when pred_taken is set, else f_pc + 2, wrapping modulo 2**13.
REQ-023 SHALL apply updates when u_valid & state==IDLE, at the entry indexed by u_pc[IDX_W-1:0].
REQ-024 SHALL handle an update hit on a branch as follows: ctr saturating-increments if u_taken, otherwise saturating-decrements; ctr holds at 00 and at 11.
REQ-025 SHALL handle an update hit with u_taken as follows: target <= u_true_pc.
REQ-026 SHALL handle an update miss with u_taken as follows: allocate with valid=1, tag, target=u_true_pc, ctr=10; this replaces any occupant.
REQ-027 SHALL handle an update miss with !u_taken as follows: no table change.
REQ-028 SHALL handle jal and jalr (u_jump_code[1]=1) as follows: ctr <= 11 on every update.
REQ-029 SHALL, when a lookup and an update hit the same index in the same cycle, return the pre-update entry for the lookup.
REQ-030 SHALL implement a two-state redirect FSM with states IDLE and PEND.
REQ-031 SHALL, in IDLE with u_valid & u_fail, register redirect_pc <= u_true_pc and go to PEND; redirect_valid=1 from the next cycle.
REQ-032 SHALL, in PEND, hold redirect_valid=1 and keep redirect_pc stable; on redirect_ready it SHALL go to IDLE with redirect_valid=0 the following cycle.
REQ-033 SHALL assert flush combinationally for exactly the cycle in which redirect_valid & redirect_ready.
REQ-034 SHALL, in PEND, ignore u_valid and u_fail (wrong path): no table update, no new redirect.
REQ-035 SHALL increment miss_cnt by 1 on each accepted u_fail (IDLE transition) and saturate at 16'hFFFF.
REQ-036 SHALL ignore u_fail when u_valid=0.

Reset
REQ-037 SHALL, while rst is high (asynchronous, immediate), clear every entry to valid=0, ctr=01, target=0.
REQ-038 SHALL, while rst is high, set state=IDLE, redirect_valid=0, redirect_pc=0 and miss_cnt=0; flush therefore reads 0.
REQ-039 SHALL, when rst is asserted during PEND, drop the pending redirect without a flush pulse.

Verification
REQ-040 SHALL cover the post-reset lookup: f_valid=1, f_pc=0x010 -> pred_taken=0, pred_pc=0x012.
REQ-041 SHALL cover the allocate-then-hit sequence: update u_pc=0x013, branch, taken, u_true_pc=0x040 -> next-cycle lookup f_pc=0x013 gives pred_taken=1, pred_pc=0x040.
REQ-042 SHALL cover counter saturation: three taken updates on one entry -> ctr=11; then two not-taken -> ctr=01 and pred_taken=0.
REQ-043 SHALL cover redirect backpressure: u_fail with u_true_pc=0x100 and redirect_ready held 0 for 3 cycles -> redirect_valid=1, redirect_pc=0x100 stable; flush=1 only in the ready cycle; miss_cnt=1.
REQ-044 SHALL cover a wrong-path fail in PEND: second u_fail (u_true_pc=0x200) during PEND -> redirect_pc stays 0x100, miss_cnt stays 1, table unchanged.
REQ-045 SHALL cover wrap-around and async reset: f_pc=0x1FFF miss -> pred_pc=0x0001; then rst pulse mid-PEND -> redirect_valid=0 immediately with no flush.
